// File: rtl/mips_pkg.sv
// Shared MIPS definitions: reset vector, instruction field positions and the
// instruction word type, used by fetch and the control unit.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned FUNC_MSB   = 5;
    localparam int unsigned FUNC_LSB   = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;

    typedef logic [XLEN-1:0] instr_t;

    function automatic logic [5:0] get_opcode(input instr_t instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [5:0] get_func(input instr_t instr);
        return instr[FUNC_MSB:FUNC_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Synchronous instruction FIFO with push/pop/flush and an occupancy count;
// head entry is read combinationally from storage.
module fetch_queue
    import mips_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  instr_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output instr_t        head_data,
    output logic [CW-1:0] count
);

    instr_t        mem_q [DEPTH];
    instr_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Push into a full queue is only legal when the head leaves the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head_data = mem_q[rd_ptr_q];
        count     = count_q;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited in-order requests to instruction
// memory, a small instruction queue toward decode, and redirect with drop of stale responses.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  func
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned DW = CW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   dec_pc_q, dec_pc_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [DW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] occupancy;
    logic [DW-1:0] credit_used;
    logic [31:0]   redirect_target;
    instr_t        head_instr;
    logic          fire, push, pop;

    // Credit covers both outstanding requests and queued words, so a response always fits.
    always_comb begin
        credit_used     = DW'(in_flight_q) + DW'(occupancy);
        imem_req_valid  = (credit_used < DW'(QDEPTH)) && !reset;
        imem_req_addr   = fetch_pc_q;
        fire            = imem_req_valid && imem_req_ready;
        redirect_target = redirect_pc & 32'hFFFF_FFFC;
        push            = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
        dec_valid       = (occupancy != '0) && !reset;
        pop             = dec_valid && dec_ready && !redirect_valid;
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        dec_pc_d    = dec_pc_q;
        drop_cnt_d  = drop_cnt_q;
        in_flight_d = in_flight_q + CW'(fire) - CW'(imem_resp_valid);
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            dec_pc_d   = redirect_target;
            // Every request still outstanding after this cycle belongs to the old path.
            drop_cnt_d = DW'(in_flight_d);
        end else begin
            if (fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                dec_pc_d = dec_pc_q + 32'd4;
            end
            if (imem_resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            dec_pc_q    <= RESET_PC;
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            dec_pc_q    <= dec_pc_d;
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (imem_resp_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_instr),
        .count     (occupancy)
    );

    always_comb begin
        dec_instr = head_instr;
        dec_pc    = dec_pc_q;
        opcode    = get_opcode(head_instr);
        func      = get_func(head_instr);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run,
// compared every cycle against a transaction-level model of the fetch path.
module tb_instr_fetch;

    localparam int unsigned QD = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [5:0]  opcode;
    logic [5:0]  func;

    instr_fetch #(
        .RESET_PC (RPC),
        .QDEPTH   (QD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .opcode          (opcode),
        .func            (func)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } pend_t;

    // Outstanding memory requests (also serves as the memory model) and
    // addresses of words the decoder should see, oldest first.
    pend_t       pend[$];
    logic [31:0] expq[$];
    logic [31:0] exp_fetch;
    int          cyc;
    int          n_vec;
    int          n_miss;
    int          nfires;
    int          k_ready_pct, k_dec_pct, k_redir_permil, k_lat_min, k_lat_max;
    bit          force_redir;
    logic [31:0] force_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        bit          m_req, m_fire, m_pop;
        logic [31:0] w;
        pend_t       p;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (!reset && pend.size() != 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend[0].addr);
        end
        imem_req_ready = ($urandom_range(99) < k_ready_pct);
        dec_ready      = ($urandom_range(99) < k_dec_pct);
        redirect_valid = force_redir || (!reset && ($urandom_range(999) < k_redir_permil));
        redirect_pc    = force_redir ? force_pc : $urandom();
        force_redir    = 1'b0;

        @(negedge clk);
        m_req = !reset && (pend.size() + expq.size() < QD);
        check("req_valid", 32'(imem_req_valid), 32'(m_req));
        if (m_req) check("req_addr", imem_req_addr, exp_fetch);
        check("dec_valid", 32'(dec_valid), 32'(!reset && expq.size() != 0));
        if (!reset && expq.size() != 0) begin
            w = mem_word(expq[0]);
            check("dec_pc", dec_pc, expq[0]);
            check("dec_instr", dec_instr, w);
            check("opcode", 32'(opcode), 32'(w[31:26]));
            check("func", 32'(func), 32'(w[5:0]));
        end

        if (reset) begin
            pend.delete();
            expq.delete();
            exp_fetch = RPC;
        end else begin
            m_fire = m_req && imem_req_ready;
            m_pop  = (expq.size() != 0) && dec_ready && !redirect_valid;
            if (m_pop) void'(expq.pop_front());
            if (imem_resp_valid) begin
                p = pend.pop_front();
                if (!p.stale && !redirect_valid) expq.push_back(p.addr);
            end
            if (m_fire) begin
                pend.push_back('{addr: exp_fetch, stale: 1'b0,
                                 due: cyc + 1 + int'($urandom_range(k_lat_max, k_lat_min))});
                exp_fetch = exp_fetch + 32'd4;
                nfires++;
            end
            if (redirect_valid) begin
                foreach (pend[i]) pend[i].stale = 1'b1;
                expq.delete();
                exp_fetch = {redirect_pc[31:2], 2'b00};
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    task automatic set_knobs(input int rdy, input int dec, input int redir, input int lmin, input int lmax);
        k_ready_pct    = rdy;
        k_dec_pct      = dec;
        k_redir_permil = redir;
        k_lat_min      = lmin;
        k_lat_max      = lmax;
    endtask

    initial begin
        bit found;
        n_vec = 0; n_miss = 0; cyc = 0; nfires = 0;
        force_redir = 1'b0; force_pc = '0; exp_fetch = RPC;
        reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        set_knobs(100, 100, 0, 0, 0);
        @(posedge clk);
        #1;

        // Sequential streaming with zero-wait, one-cycle-latency memory.
        do_reset();
        check("first_req_addr", imem_req_addr, RPC);
        repeat (30) cycle();

        // Decoder stalled: credit fills the queue and requests stop.
        do_reset();
        set_knobs(100, 0, 0, 0, 0);
        nfires = 0;
        repeat (10) cycle();
        check("stall_fires", 32'(nfires), 32'(QD));
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_dec_valid", 32'(dec_valid), 32'd1);
        set_knobs(100, 100, 0, 0, 0);
        repeat (4) cycle();

        // Redirect with two requests outstanding drops both responses.
        do_reset();
        set_knobs(100, 100, 0, 3, 3);
        repeat (2) cycle();
        check("inflight_before_redir", 32'(pend.size()), 32'd2);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0100;
        cycle();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (dec_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("redir_arrived", 32'(found), 32'd1);
        check("redir_dec_pc", dec_pc, 32'h0000_0100);
        check("redir_dec_instr", dec_instr, mem_word(32'h0000_0100));

        // Unaligned redirect target fetches from the aligned word.
        set_knobs(100, 100, 0, 0, 0);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0203;
        cycle();
        check("align_fetch_addr", imem_req_addr, 32'h0000_0200);
        repeat (8) cycle();

        // Redirect colliding with a response and a dequeue.
        do_reset();
        set_knobs(100, 100, 0, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dec_valid && pend.size() != 0 && pend[0].due <= cyc) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        check("collide_setup", 32'(found), 32'd1);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0400;
        cycle();
        check("collide_dec_valid", 32'(dec_valid), 32'd0);
        repeat (10) cycle();

        // Reset during a full-queue stall.
        set_knobs(100, 0, 0, 0, 0);
        repeat (8) cycle();
        check("pre_reset_full", 32'(dec_valid), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("post_reset_dec_valid", 32'(dec_valid), 32'd0);
        check("post_reset_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_reset_addr", imem_req_addr, RPC);
        set_knobs(100, 100, 0, 0, 0);
        repeat (10) cycle();

        // Randomized traffic with variable latency and redirects.
        set_knobs(70, 60, 40, 0, 3);
        repeat (3000) cycle();
        set_knobs(40, 90, 150, 0, 5);
        repeat (1500) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
